// File: rtl/mips_pkg.sv
// Shared encodings for the 8-bit multicycle MIPS control unit.
// MIPS_CTRL_ADDI_EN adds the ADDIEX/ADDIWR path for opcode 001000.
package mips_pkg;

   localparam int STATE_W = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LB   = 6'b100000;
   localparam logic [5:0] OP_SB   = 6'b101000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_FN  = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      FETCH1  = 4'd0,
      FETCH2  = 4'd1,
      FETCH3  = 4'd2,
      FETCH4  = 4'd3,
      DECODE  = 4'd4,
      MEMADR  = 4'd5,
      LBRD    = 4'd6,
      LBWR    = 4'd7,
      SBWR    = 4'd8,
      RTYPEEX = 4'd9,
      RTYPEWR = 4'd10,
      BEQEX   = 4'd11,
      JEX     = 4'd12,
      ADDIEX  = 4'd13,
      ADDIWR  = 4'd14
   } state_t;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       iord;
      logic [3:0] irwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
   } ctrl_t;

   function automatic logic is_legal(logic [5:0] op);
      logic ok;
      ok = (op == OP_R) || (op == OP_LB) || (op == OP_SB)
         || (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_CTRL_ADDI_EN
      ok = ok || (op == OP_ADDI);
`endif
      return ok;
   endfunction

   function automatic state_t next_state(state_t s, logic [5:0] op);
      state_t n;
      n = FETCH1;
      unique case (s)
         FETCH1:  n = FETCH2;
         FETCH2:  n = FETCH3;
         FETCH3:  n = FETCH4;
         FETCH4:  n = DECODE;
         DECODE: begin
            unique case (1'b1)
               (op == OP_LB) || (op == OP_SB): n = MEMADR;
               op == OP_R:   n = RTYPEEX;
               op == OP_BEQ: n = BEQEX;
               op == OP_J:   n = JEX;
`ifdef MIPS_CTRL_ADDI_EN
               op == OP_ADDI: n = ADDIEX;
`endif
               default: n = FETCH1;
            endcase
         end
         MEMADR:  n = (op == OP_LB) ? LBRD : SBWR;
         LBRD:    n = LBWR;
         RTYPEEX: n = RTYPEWR;
`ifdef MIPS_CTRL_ADDI_EN
         ADDIEX:  n = ADDIWR;
`endif
         default: n = FETCH1;
      endcase
      return n;
   endfunction

   function automatic ctrl_t decode(state_t s);
      ctrl_t c;
      c = '0;
      unique case (s)
         FETCH1, FETCH2, FETCH3, FETCH4: begin
            c.memread = 1'b1;
            c.irwrite = 4'b0001 << s[1:0];
            c.alusrcb = 2'b01;
            c.pcwrite = 1'b1;
         end
         DECODE: c.alusrcb = 2'b11;
         MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         LBRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         LBWR: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         SBWR: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         RTYPEEX: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_FN;
         end
         RTYPEWR: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         BEQEX: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_SUB;
            c.branch  = 1'b1;
            c.pcsrc   = 2'b01;
         end
         JEX: begin
            c.pcwrite = 1'b1;
            c.pcsrc   = 2'b10;
         end
`ifdef MIPS_CTRL_ADDI_EN
         ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         ADDIWR: c.regwrite = 1'b1;
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_controller_if.sv
// Control bundle between the MIPS controller and its datapath.
interface mips_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memread;
   logic       memwrite;
   logic       iord;
   logic [3:0] irwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [2:0] alucontrol;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       illegal_op;

   modport master (
      input  op, funct, zero,
      output memread, memwrite, iord, irwrite,
      output alusrca, alusrcb, alucontrol, pcsrc,
      output pcen, regwrite, regdst, memtoreg, illegal_op
   );

   modport slave (
      output op, funct, zero,
      input  memread, memwrite, iord, irwrite,
      input  alusrca, alusrcb, alucontrol, pcsrc,
      input  pcen, regwrite, regdst, memtoreg, illegal_op
   );
endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: ALUOp plus R-type funct select the 3-bit ALU operation.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);
   always_comb begin
      alucontrol = ALU_ADD;
      unique case (1'b1)
         aluop == ALUOP_SUB:                  alucontrol = ALU_SUB;
         (aluop == ALUOP_FN) && (funct == F_SUB): alucontrol = ALU_SUB;
         (aluop == ALUOP_FN) && (funct == F_AND): alucontrol = ALU_AND;
         (aluop == ALUOP_FN) && (funct == F_OR):  alucontrol = ALU_OR;
         (aluop == ALUOP_FN) && (funct == F_SLT): alucontrol = ALU_SLT;
         default:                              alucontrol = ALU_ADD;
      endcase
   end
endmodule

// File: rtl/mips_controller.sv
// Multicycle Moore control FSM for the 8-bit MIPS datapath.
// MIPS_CTRL_ADDI_EN enables the ADDI execute/writeback states.
module mips_controller
   import mips_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   mips_controller_if.master  bus
);
   logic [STATE_W-1:0] st;
   state_t             cur;
   state_t             nxt;
   ctrl_t              ctl;
   logic [2:0]         aluctl;

   assign cur = state_t'(st);
   assign nxt = next_state(cur, bus.op);

   // Control word is registered alongside the state, so it always matches cur.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         st  <= STATE_W'(FETCH1);
         ctl <= decode(FETCH1);
      end else begin
         st  <= STATE_W'(nxt);
         ctl <= decode(nxt);
      end
   end

   alu_decoder u_alu_decoder (
      .aluop      (ctl.aluop),
      .funct      (bus.funct),
      .alucontrol (aluctl)
   );

   assign bus.memread    = ctl.memread;
   assign bus.iord       = ctl.iord;
   assign bus.alusrca    = ctl.alusrca;
   assign bus.alusrcb    = ctl.alusrcb;
   assign bus.alucontrol = aluctl;
   assign bus.pcsrc      = ctl.pcsrc;
   assign bus.regdst     = ctl.regdst;
   assign bus.memtoreg   = ctl.memtoreg;

   // Side-effecting strobes are held off for the whole reset window.
   assign bus.memwrite   = reset_n & ctl.memwrite;
   assign bus.regwrite   = reset_n & ctl.regwrite;
   assign bus.irwrite    = ctl.irwrite & {4{reset_n}};
   assign bus.pcen       = reset_n
                         & (ctl.pcwrite | (ctl.branch & bus.zero));
   assign bus.illegal_op = reset_n & (cur == DECODE)
                         & ~is_legal(bus.op);
endmodule

// File: tb/tb_mips_controller.sv
// Randomised self-checking bench for mips_controller.
module tb_mips_controller;

   localparam int C_LB = 0, C_SB = 1, C_R = 2, C_BEQ = 3;
   localparam int C_J = 4, C_ADDI = 5, C_ILL = 6;

   logic clock;
   logic reset_n;
   int   compared;
   int   mismatched;
   int   cur_cls;
   int   cur_k;
   logic [19:0] samp [0:7];

   mips_controller_if bus ();

   mips_controller #(.STATE_W(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic int cls_of(logic [5:0] o);
      case (o)
         6'b100000: return C_LB;
         6'b101000: return C_SB;
         6'b000000: return C_R;
         6'b000100: return C_BEQ;
         6'b000010: return C_J;
`ifdef MIPS_CTRL_ADDI_EN
         6'b001000: return C_ADDI;
`endif
         default:   return C_ILL;
      endcase
   endfunction

   function automatic int len_of(int c);
      case (c)
         C_LB:   return 8;
         C_SB:   return 7;
         C_R:    return 7;
         C_BEQ:  return 6;
         C_J:    return 6;
         C_ADDI: return 7;
         default: return 5;
      endcase
   endfunction

   function automatic logic [2:0] alu_ref(logic [5:0] f);
      case (f)
         6'd34:   return 3'b110;
         6'd36:   return 3'b000;
         6'd37:   return 3'b001;
         6'd42:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   // Expected outputs by instruction class and cycle number within it.
   function automatic logic [19:0] expv(int c, int k, logic [5:0] f, logic z);
      logic mr, mw, io, sa, pe, rw, rd, mt, il;
      logic [3:0] ir;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      {mr, mw, io, sa, pe, rw, rd, mt, il} = '0;
      ir = '0; sb = '0; ps = '0; ac = 3'b010;
      if (k < 4) begin
         mr = 1; ir = 4'(1 << k); sb = 2'b01; pe = 1;
      end else if (k == 4) begin
         sb = 2'b11; il = (c == C_ILL);
      end else begin
         case (c)
            C_LB:
               if (k == 5) begin sa = 1; sb = 2'b10; end
               else if (k == 6) begin mr = 1; io = 1; end
               else begin rw = 1; mt = 1; end
            C_SB:
               if (k == 5) begin sa = 1; sb = 2'b10; end
               else begin mw = 1; io = 1; end
            C_R:
               if (k == 5) begin sa = 1; ac = alu_ref(f); end
               else begin rw = 1; rd = 1; end
            C_BEQ: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
            C_J:   begin pe = 1; ps = 2'b10; end
            C_ADDI:
               if (k == 5) begin sa = 1; sb = 2'b10; end
               else rw = 1;
            default: ;
         endcase
      end
      return {mr, mw, io, ir, sa, sb, ac, ps, pe, rw, rd, mt, il};
   endfunction

   function automatic logic [19:0] outv();
      return {bus.memread, bus.memwrite, bus.iord, bus.irwrite,
              bus.alusrca, bus.alusrcb, bus.alucontrol, bus.pcsrc,
              bus.pcen, bus.regwrite, bus.regdst, bus.memtoreg,
              bus.illegal_op};
   endfunction

   task automatic check(input string nm, input logic [19:0] got,
                        input logic [19:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s cls=%0d cyc=%0d got=%b want=%b",
                  nm, cur_cls, cur_k, got, exp);
      end
   endtask

   task automatic pin(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL pin_%s got=%0h want=%0h", nm, got, exp);
      end
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         check("reset_gate",
               {15'd0, bus.memwrite, bus.regwrite, bus.pcen,
                |bus.irwrite, bus.illegal_op}, 20'd0);
         @(posedge clock);
         #1;
      end
      reset_n = 1'b1;
   endtask

   // zmode 0/1 holds zero fixed; 2 toggles it randomly every cycle.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input int zmode, input int rst_at);
      int c, n;
      logic [19:0] got;
      c = cls_of(o);
      n = len_of(c);
      bus.op = o;
      bus.funct = f;
      cur_cls = c;
      for (int k = 0; k < n; k++) begin
         cur_k = k;
         if (k == rst_at) begin
            do_reset(($urandom_range(0, 1) == 0) ? 1 : 2);
            return;
         end
         bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         @(negedge clock);
         got = outv();
         samp[k] = got;
         check("cycle", got, expv(c, k, f, bus.zero));
         @(posedge clock);
         #1;
      end
   endtask

   logic [5:0] ops [0:6];
   logic [5:0] fns [0:5];

   initial begin
      compared = 0;
      mismatched = 0;
      cur_cls = 0;
      cur_k = 0;
      bus.op = 6'd0;
      bus.funct = 6'd0;
      bus.zero = 1'b0;
      reset_n = 1'b0;
      ops = '{6'b100000, 6'b101000, 6'b000000, 6'b000100,
              6'b000010, 6'b001000, 6'b111111};
      fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd7};
      @(posedge clock);
      #1;
      do_reset(2);

      run_instr(6'b000000, 6'b100010, 2, -1);
      pin("ir0", 8'(samp[0][16:13]), 8'h1);
      pin("ir1", 8'(samp[1][16:13]), 8'h2);
      pin("ir2", 8'(samp[2][16:13]), 8'h4);
      pin("ir3", 8'(samp[3][16:13]), 8'h8);
      pin("rsub_alu", 8'(samp[5][9:7]), 8'h6);
      pin("rwr", 8'({samp[6][3], samp[6][2]}), 8'h3);

      run_instr(6'b000000, 6'b100000, 2, 6);
      run_instr(6'b100000, 6'b100101, 2, -1);
      pin("lb_srcb", 8'(samp[5][11:10]), 8'h2);
      pin("lb_rd", 8'({samp[6][19], samp[6][17]}), 8'h3);
      pin("lb_wr", 8'({samp[7][3], samp[7][1]}), 8'h3);

      run_instr(6'b000100, 6'b000000, 1, -1);
      pin("beq_t", 8'({samp[5][4], samp[5][6:5]}), 8'h5);
      run_instr(6'b000100, 6'b000000, 0, -1);
      pin("beq_nt", 8'(samp[5][4]), 8'h0);

      run_instr(6'b000010, 6'b000000, 2, -1);
      pin("jex", 8'({samp[5][4], samp[5][6:5]}), 8'h6);
      run_instr(6'b111111, 6'b000000, 2, -1);
      pin("ill", 8'(samp[4][0]), 8'h1);

      run_instr(6'b001000, 6'b000000, 2, -1);
`ifdef MIPS_CTRL_ADDI_EN
      pin("addi_wr", 8'(samp[6][3]), 8'h1);
`else
      pin("addi_ill", 8'(samp[4][0]), 8'h1);
`endif

      for (int i = 0; i < 300; i++) begin
         logic [5:0] o;
         logic [5:0] f;
         int ra;
         o = ops[$urandom_range(0, 6)];
         if (o == 6'b111111) o = 6'($urandom);
         f = fns[$urandom_range(0, 5)];
         if (f == 6'd7) f = 6'($urandom);
         ra = -1;
         if ($urandom_range(0, 19) == 0)
            ra = $urandom_range(0, len_of(cls_of(o)) - 1);
         run_instr(o, f, 2, ra);
      end
      run_instr(6'b000000, 6'b101010, 2, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
